// File: rtl/register_file_pkg.sv
// Shared sizing constants for the rename register file and its read ports.
// x0 has no storage and tag 0 means "value is architectural, no producer in flight".
package register_file_pkg;
  localparam int NREG     = 32;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;
  localparam int NO_DEP   = 0;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/register_file_if.sv
// ROB-side bus into the register file: launch/commit/flush plus two source lookups.
interface register_file_if #(
  parameter int ROB_ID_W = 5,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32
);
  logic                _clear;
  logic                _rf_launch_ready;
  logic [ROB_ID_W-1:0] _rf_launch_rob_id;
  logic [REG_W-1:0]    _rf_launch_register_id;
  logic                _rf_commit_ready;
  logic [ROB_ID_W-1:0] _rf_commit_rob_id;
  logic [REG_W-1:0]    _rf_commit_register_id;
  logic [DATA_W-1:0]   _rf_commit_value;
  logic [REG_W-1:0]    _ask_rd_1;
  logic [REG_W-1:0]    _ask_rd_2;
  logic [ROB_ID_W-1:0] _dep_rd_1;
  logic [ROB_ID_W-1:0] _dep_rd_2;
  logic [DATA_W-1:0]   _dep_value_1;
  logic [DATA_W-1:0]   _dep_value_2;

  modport master (
    output _clear, _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
           _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
           _ask_rd_1, _ask_rd_2,
    input  _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
  );

  modport slave (
    input  _clear, _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
           _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id, _rf_commit_value,
           _ask_rd_1, _ask_rd_2,
    output _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
  );
endinterface

// File: rtl/register_file_read_port.sv
// One combinational source lookup with same-cycle forwarding of a matching commit.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int NREG       = register_file_pkg::NREG,
  parameter int ROB_ID_W   = register_file_pkg::ROB_ID_W,
  parameter int DATA_W     = register_file_pkg::DATA_W,
  localparam int REG_W     = $clog2(NREG)
) (
  input  logic                rst_in,
  input  logic [REG_W-1:0]    ask_rd,
  input  logic                commit_ready,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [REG_W-1:0]    commit_register_id,
  input  logic [DATA_W-1:0]   commit_value,
  input  logic [ROB_ID_W-1:0] tag_arr   [NREG],
  input  logic [DATA_W-1:0]   value_arr [NREG],
  output logic [ROB_ID_W-1:0] dep_rd,
  output logic [DATA_W-1:0]   dep_value
);
  logic forward;

  // Forward only when the retiring instruction is still the register's latest producer.
  assign forward = commit_ready && (ask_rd == commit_register_id)
                && (tag_arr[ask_rd] == commit_rob_id);

  always_comb begin
    dep_rd    = ROB_ID_W'(NO_DEP);
    dep_value = '0;
    if (!rst_in && ask_rd != REG_W'(ZERO_REG)) begin
      if (forward) begin
        dep_value = commit_value;
      end else begin
        dep_rd    = tag_arr[ask_rd];
        dep_value = value_arr[ask_rd];
      end
    end
  end
endmodule

// File: rtl/register_file.sv
// Architectural value + pending-producer tag per register, with launch/commit/flush
// updates and two forwarding read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int NREG     = register_file_pkg::NREG,
  parameter int ROB_ID_W = register_file_pkg::ROB_ID_W,
  localparam int REG_W   = $clog2(NREG)
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  register_file_if.slave rf
);
  logic [ROB_ID_W-1:0] tag_reg   [NREG];
  logic [DATA_W-1:0]   value_reg [NREG];
  logic [NREG-1:0]     commit_hit;
  logic [NREG-1:0]     launch_hit;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_decode
    if (gi == ZERO_REG) begin : g_zero
      assign commit_hit[gi] = 1'b0;
      assign launch_hit[gi] = 1'b0;
    end else begin : g_live
      assign commit_hit[gi] = rf._rf_commit_ready && (rf._rf_commit_register_id == REG_W'(gi));
      assign launch_hit[gi] = rf._rf_launch_ready && (rf._rf_launch_register_id == REG_W'(gi));
    end
  end

  // Entry 0 is only ever reset, so it stays a constant zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        value_reg[i] <= '0;
        tag_reg[i]   <= ROB_ID_W'(NO_DEP);
      end
    end else if (rdy_in) begin
      for (int i = 1; i < NREG; i++) begin
        if (commit_hit[i]) begin
          value_reg[i] <= rf._rf_commit_value;
        end
        // Flush beats launch; a newer launch beats the older producer's commit.
        if (rf._clear) begin
          tag_reg[i] <= ROB_ID_W'(NO_DEP);
        end else if (launch_hit[i]) begin
          tag_reg[i] <= rf._rf_launch_rob_id;
        end else if (commit_hit[i] && tag_reg[i] == rf._rf_commit_rob_id) begin
          tag_reg[i] <= ROB_ID_W'(NO_DEP);
        end
      end
    end
  end

  register_file_read_port #(.NREG(NREG), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_port_1 (
    .rst_in             (rst_in),
    .ask_rd             (rf._ask_rd_1),
    .commit_ready       (rf._rf_commit_ready),
    .commit_rob_id      (rf._rf_commit_rob_id),
    .commit_register_id (rf._rf_commit_register_id),
    .commit_value       (rf._rf_commit_value),
    .tag_arr            (tag_reg),
    .value_arr          (value_reg),
    .dep_rd             (rf._dep_rd_1),
    .dep_value          (rf._dep_value_1)
  );

  register_file_read_port #(.NREG(NREG), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_port_2 (
    .rst_in             (rst_in),
    .ask_rd             (rf._ask_rd_2),
    .commit_ready       (rf._rf_commit_ready),
    .commit_rob_id      (rf._rf_commit_rob_id),
    .commit_register_id (rf._rf_commit_register_id),
    .commit_value       (rf._rf_commit_value),
    .tag_arr            (tag_reg),
    .value_arr          (value_reg),
    .dep_rd             (rf._dep_rd_2),
    .dep_value          (rf._dep_value_2)
  );
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: behavioural model checked every negedge plus
// hand-computed literal expectations for the key scenarios.
module tb_register_file;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  register_file_if #(.ROB_ID_W(5), .REG_W(5), .DATA_W(32)) rf ();

  register_file #(.NREG(32), .ROB_ID_W(5)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rf     (rf.slave)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: architectural value and newest pending producer per register.
  logic [31:0] m_val [32];
  logic [4:0]  m_tag [32];

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] <= 32'h0;
        m_tag[i] <= 5'd0;
      end
    end else if (rdy_in) begin
      if (rf._rf_commit_ready && rf._rf_commit_register_id != 0)
        m_val[rf._rf_commit_register_id] <= rf._rf_commit_value;
      if (rf._clear) begin
        for (int i = 0; i < 32; i++) m_tag[i] <= 5'd0;
      end else begin
        if (rf._rf_commit_ready && rf._rf_commit_register_id != 0
            && m_tag[rf._rf_commit_register_id] == rf._rf_commit_rob_id)
          m_tag[rf._rf_commit_register_id] <= 5'd0;
        if (rf._rf_launch_ready && rf._rf_launch_register_id != 0)
          m_tag[rf._rf_launch_register_id] <= rf._rf_launch_rob_id;
      end
    end
  end

  function automatic logic fwd(input logic [4:0] a);
    return rf._rf_commit_ready && a == rf._rf_commit_register_id
        && m_tag[a] == rf._rf_commit_rob_id;
  endfunction

  function automatic logic [4:0] exp_dep(input logic [4:0] a);
    if (rst_in || a == 0 || fwd(a)) return 5'd0;
    return m_tag[a];
  endfunction

  function automatic logic [31:0] exp_val(input logic [4:0] a);
    if (rst_in || a == 0) return 32'h0;
    if (fwd(a)) return rf._rf_commit_value;
    return m_val[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("cmp_dep1", 32'(rf._dep_rd_1),    32'(exp_dep(rf._ask_rd_1)));
      check("cmp_val1", rf._dep_value_1,      exp_val(rf._ask_rd_1));
      check("cmp_dep2", 32'(rf._dep_rd_2),    32'(exp_dep(rf._ask_rd_2)));
      check("cmp_val2", rf._dep_value_2,      exp_val(rf._ask_rd_2));
      $display("[TB] cyc t=%0t ask %0d/%0d dep %0d/%0d val %h/%h", $time, rf._ask_rd_1,
               rf._ask_rd_2, rf._dep_rd_1, rf._dep_rd_2, rf._dep_value_1, rf._dep_value_2);
    end
  end

  task automatic idle();
    rdy_in = 1'b1;
    rf._clear = 1'b0;
    rf._rf_launch_ready = 1'b0;
    rf._rf_launch_rob_id = 5'd0;
    rf._rf_launch_register_id = 5'd0;
    rf._rf_commit_ready = 1'b0;
    rf._rf_commit_rob_id = 5'd0;
    rf._rf_commit_register_id = 5'd0;
    rf._rf_commit_value = 32'h0;
    rf._ask_rd_1 = 5'd0;
    rf._ask_rd_2 = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic launch(input logic [4:0] r, input logic [4:0] id);
    rf._rf_launch_ready = 1'b1;
    rf._rf_launch_register_id = r;
    rf._rf_launch_rob_id = id;
  endtask

  task automatic commit(input logic [4:0] r, input logic [4:0] id, input logic [31:0] v);
    rf._rf_commit_ready = 1'b1;
    rf._rf_commit_register_id = r;
    rf._rf_commit_rob_id = id;
    rf._rf_commit_value = v;
  endtask

  task automatic ask(input logic [4:0] a1, input logic [4:0] a2);
    rf._ask_rd_1 = a1;
    rf._ask_rd_2 = a2;
    #1;
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    ask(5, 0);
    check("rst_dep5", 32'(rf._dep_rd_1), 32'd0);
    check("rst_val5", rf._dep_value_1, 32'h0);
    rst_in = 1'b0;
    tick();

    // Launch visible only next cycle
    launch(5, 3); ask(5, 5);
    check("launch_same_cycle_dep", 32'(rf._dep_rd_1), 32'd0);
    tick(); idle(); ask(5, 0);
    check("launch_dep5", 32'(rf._dep_rd_1), 32'd3);
    check("launch_val5", rf._dep_value_1, 32'h0);

    // Commit forwarding, then same result from state
    commit(5, 3, 32'h1234); ask(5, 5);
    check("fwd_dep5", 32'(rf._dep_rd_2), 32'd0);
    check("fwd_val5", rf._dep_value_2, 32'h1234);
    tick(); idle(); ask(5, 0);
    check("commit_dep5", 32'(rf._dep_rd_1), 32'd0);
    check("commit_val5", rf._dep_value_1, 32'h1234);

    // Stale commit writes value but keeps the newer tag
    launch(5, 3); tick(); idle();
    launch(5, 7); tick(); idle();
    commit(5, 3, 32'hAA); ask(5, 0);
    check("stale_nofwd_val", rf._dep_value_1, 32'h1234);
    tick(); idle(); ask(5, 0);
    check("stale_dep5", 32'(rf._dep_rd_1), 32'd7);
    check("stale_val5", rf._dep_value_1, 32'hAA);

    // Launch and commit same register, same cycle
    commit(6, 2, 32'h55); launch(6, 9); tick(); idle(); ask(6, 0);
    check("both_dep6", 32'(rf._dep_rd_1), 32'd9);
    check("both_val6", rf._dep_value_1, 32'h55);

    // Flush
    launch(1, 1); tick(); idle();
    launch(2, 2); tick(); idle();
    launch(31, 4); tick(); idle(); ask(31, 2);
    check("pre_clear_dep31", 32'(rf._dep_rd_1), 32'd4);
    rf._clear = 1'b1; launch(3, 6); commit(7, 8, 32'h77); tick(); idle();
    ask(31, 1);
    check("clear_dep31", 32'(rf._dep_rd_1), 32'd0);
    check("clear_dep1", 32'(rf._dep_rd_2), 32'd0);
    ask(3, 5);
    check("clear_launch_ignored", 32'(rf._dep_rd_1), 32'd0);
    check("clear_keeps_val5", rf._dep_value_2, 32'hAA);
    ask(7, 0);
    check("clear_commit_val7", rf._dep_value_1, 32'h77);

    // x0 writes discarded
    launch(0, 5); commit(0, 0, 32'hDEAD); ask(0, 0);
    check("x0_fwd_val", rf._dep_value_1, 32'h0);
    tick(); idle(); ask(0, 0);
    check("x0_dep", 32'(rf._dep_rd_1), 32'd0);
    check("x0_val", rf._dep_value_2, 32'h0);

    // rdy_in low holds state
    rdy_in = 1'b0; launch(4, 4); commit(5, 0, 32'hBEEF); tick(); idle(); ask(4, 5);
    check("stall_dep4", 32'(rf._dep_rd_1), 32'd0);
    check("stall_val5", rf._dep_value_2, 32'hAA);

    // Mixed directed vectors checked by the model
    launch(10, 11); commit(5, 0, 32'hC0DE); ask(10, 5); tick(); idle();
    launch(11, 12); commit(10, 11, 32'hA10); ask(10, 11); tick(); idle();
    launch(10, 13); commit(11, 12, 32'hB11); ask(10, 11); tick(); idle();
    commit(10, 13, 32'hC10); ask(10, 11); tick(); idle();
    ask(10, 11);
    check("vec_val10", rf._dep_value_1, 32'hC10);
    check("vec_val11", rf._dep_value_2, 32'hB11);

    // Asynchronous reset mid-cycle, with a tag-0 commit that would otherwise forward
    launch(12, 14); tick(); idle();
    commit(5, 0, 32'h99); ask(5, 12);
    #2 rst_in = 1'b1;
    #1;
    check("arst_dep12", 32'(rf._dep_rd_2), 32'd0);
    check("arst_val5", rf._dep_value_1, 32'h0);
    tick(); idle(); rst_in = 1'b0; ask(5, 12);
    check("post_rst_val5", rf._dep_value_1, 32'h0);
    check("post_rst_dep12", 32'(rf._dep_rd_2), 32'd0);
    tick();
    @(negedge clk_in);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; x0 is hard-wired to zero.
REQ-002 Parameter ROB_ID_W, default 5: ROB tag width; tag 0 means "no pending producer" (ROB ids run 1..31).
REQ-003 clk_in  input  1  system clock; one clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset; asynchronous, active-high.
REQ-005 rdy_in  input  1  ready; when low, no state changes.
REQ-006 _clear  input  1  mispredict flush from ROB.
REQ-007 _rf_launch_ready  input  1  an issued instruction with a destination register is being allocated this cycle.
REQ-008 _rf_launch_rob_id  input  5  ROB tag of the allocated instruction.
REQ-009 _rf_launch_register_id  input  5  destination register of the allocated instruction.
REQ-010 _rf_commit_ready  input  1  head instruction with a destination register is retiring this cycle.
REQ-011 _rf_commit_rob_id  input  5  ROB tag of the retiring instruction.
REQ-012 _rf_commit_register_id  input  5  destination register of the retiring instruction.
REQ-013 _rf_commit_value  input  32  architectural result.
REQ-014 _ask_rd_1, _ask_rd_2  input  5 each  source register lookups from decode (via ROB).
REQ-015 _dep_rd_1, _dep_rd_2  output  5 each  pending ROB tag for the source, 0 if none.
REQ-016 _dep_value_1, _dep_value_2  output  32 each  architectural value of the source.

Function
REQ-017 State: value[1..31] (32 bit) and tag[1..31] (5 bit); x0 has no storage.
REQ-018 Lookups are combinational, zero latency: _dep_rd_n = tag[_ask_rd_n], _dep_value_n = value[_ask_rd_n].
REQ-019 _ask_rd_n == 0 SHALL return dep 0 and value 0 under all conditions.
REQ-020 Commit forwarding: if _rf_commit_ready, _ask_rd_n == _rf_commit_register_id != 0 and tag[reg] == _rf_commit_rob_id, outputs are dep 0 and value _rf_commit_value in the same cycle.
REQ-021 Launch is not forwarded to lookups in the same cycle; a launch becomes visible in the following cycle.
REQ-022 Commit (rdy_in high): value[reg] <= _rf_commit_value for reg != 0; tag[reg] <= 0 only if tag[reg] == _rf_commit_rob_id.
REQ-023 Launch (rdy_in high, no _clear): tag[reg] <= _rf_launch_rob_id for reg != 0.
REQ-024 Launch and commit to the same register in one cycle: value takes the commit value; tag takes the launch tag (launch wins).
REQ-025 Writes to register 0 by launch or commit are discarded.
REQ-026 _clear with rdy_in high: all tags <= 0; a same-cycle commit value write is still applied; a same-cycle launch is ignored.
REQ-027 rdy_in low: value and tag arrays hold; lookups remain combinationally valid.

Reset
REQ-028 rst_in high asynchronously forces all value[] and tag[] entries to 0; all outputs read 0 while reset is asserted.
REQ-029 Reset takes priority over _clear, launch and commit, including mid-operation; the first update is on the first rising edge after rst_in deasserts.

Structure
REQ-030 Shared package holds NREG, ROB_ID_W, the NO_DEP tag constant (0) and the ZERO_REG index.
REQ-031 One sub-module, register_file_read_port, implements lookup plus commit forwarding and is instantiated twice.

Verification
REQ-032 Reset, then ask x5 -> dep 0, value 0; launch x5 tag 3, next cycle ask x5 -> dep 3, value 0.
REQ-033 Launch x5 tag 3; later commit x5 tag 3 value 0x1234 -> same-cycle ask x5 gives dep 0, value 0x1234; next cycle identical from state.
REQ-034 Launch x5 tag 3, then launch x5 tag 7, then commit tag 3 value 0xAA -> value 0xAA, dep stays 7.
REQ-035 Same cycle: commit x6 tag 2 value 0x55 and launch x6 tag 9 -> next cycle dep 9, value 0x55.
REQ-036 Tags pending on x1, x2, x31; assert _clear with rdy_in high -> next cycle all deps 0, values unchanged; launch/commit to x0 -> x0 reads 0.
REQ-037 rdy_in low with launch x4 tag 4 -> x4 dep stays 0; assert rst_in asynchronously mid-cycle -> all outputs 0 before next edge.
